rem_sign: RTL and testbench
===========================

# rem_sign

Sequential remainder-sign stage that sits directly upstream of the divider rounding stages (`round_ne` / `round_z`). It accepts a dividend `a`, divisor `b` and candidate quotient `q`, and computes the exact remainder R = a·2^(WIDTH-1) − q·b with an iterative radix-2^RADIX_BITS shift-add multiplier. It forwards `q` unchanged together with one-hot remainder-sign flags. The rounding stage consumes the result.

## Interface
- `WIDTH`, 28: operand and quotient width. `a`, `b` and `q` are unsigned Q1.(WIDTH-1).
- `ULP`, 4: guard-bit count. It is forwarded for the downstream rounding stage and is not used arithmetically here.
- `RADIX_BITS`, 2: quotient bits consumed per multiply cycle. It must divide `WIDTH` exactly; elaboration fails otherwise.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: operands valid.
- `in_ready` output 1: block can accept operands.
- `a` input WIDTH: dividend.
- `b` input WIDTH: divisor.
- `q` input WIDTH: candidate quotient, including guard bits.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer takes the result.
- `q_out` output WIDTH: registered copy of the accepted `q`.
- `rem_is_positive` output 1: R > 0.
- `rem_is_negative` output 1: R < 0.
- `rem_is_zero` output 1: R == 0.

## Operation
- **States:** IDLE, MUL, SUB, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, register `a`, `b`, `q`, clear the product accumulator and step counter, and go to MUL.
- **MUL:**
  - Each cycle adds (low RADIX_BITS of the shifted q)·b, shifted left by RADIX_BITS·step, into the 2·WIDTH-bit accumulator.
  - Shifts the q register right by RADIX_BITS and increments the step counter.
  - After N = WIDTH/RADIX_BITS steps, goes to SUB.
- **SUB:**
  - R = zero-extend(a)<<(WIDTH-1) − product, computed at 2·WIDTH+1 bits signed. This width cannot overflow for any operand values.
  - Registers the three flags (exactly one set) and goes to DONE.
- **DONE:**
  - `out_valid`=1.
  - `q_out` and the flags are held stable while `out_ready`=0.
  - On `out_ready`=1, go to IDLE.
- **Outputs outside DONE:**
  - `out_valid`=0.
  - `q_out` and the flags keep their last values; they are only meaningful while `out_valid`=1.
- **No special cases:**
  - b=0 or q=0 gives product=0. R is then positive if a≠0 and zero if a=0.
  - All-ones operands need no special handling.
- **Reset (including mid-operation):**
  - State goes to IDLE and any operation in flight is discarded.
  - `out_valid`=0, `in_ready`=1.
  - `q_out`=0 and all three flags=0.

## Timing
- Acceptance edge = edge 0.
- MUL steps occur on edges 1..N; SUB occurs on edge N+1.
- `out_valid` rises after edge N+1, which is edge 15 for the default parameters.
- No pipelining:
  - `in_ready`=0 from the acceptance edge until the edge on which the output is taken.
  - `in_ready` returns to 1 in the cycle after that edge; there is no same-cycle accept bypass.
- Throughput is one operation per N+3 cycles with `out_ready` held at 1.
- `in_valid`, `a`, `b` and `q` are ignored while not in IDLE.

## Structure
- **Shared package `div_pkg`:**
  - typedef for the state enum (`rem_state_t`).
  - helper function `rem_width(WIDTH)` returning 2·WIDTH+1.
- **Sub-module `rem_mul_step`:**
  - Combinational: accumulator, b, RADIX_BITS-bit digit and step index in; next accumulator out.
  - Instantiated once inside `rem_sign`.
- **Elaboration check:** a generate-time assertion enforces `WIDTH % RADIX_BITS == 0`.

## Test plan
All scenarios use WIDTH=28, RADIX_BITS=2, ULP=4.
- **Exact quotient:** a=b=q=0x8000000 → `rem_is_zero`=1, `q_out`=0x8000000, `out_valid` first high exactly 15 edges after acceptance.
- **Quotient one LSB low:** a=b=0x8000000, q=0x7FFFFFF → `rem_is_positive`=1 (R=0x8000000).
- **Quotient one LSB high:** a=b=0x8000000, q=0x8000001 → `rem_is_negative`=1 (R=−0x8000000).
- **Zero and all-ones operands:**
  - a=b=0, q=0xFFFFFFF → `rem_is_zero`=1.
  - a=0xFFFFFFF, b=0xFFFFFFF, q=0xFFFFFFF → `rem_is_negative`=1, no overflow.
- **Backpressure:**
  - Hold `out_ready`=0 for 5 cycles in DONE → `out_valid`=1, `q_out` and flags unchanged, `in_ready`=0 throughout.
  - Then assert `out_ready` for one cycle → `in_ready`=1 on the following cycle.
  - A new operand presented during DONE is not accepted.
- **Reset mid-MUL:**
  - Assert `reset` on MUL step 5 → next cycle `out_valid`=0, `in_ready`=1, `q_out`=0, all flags 0.
  - Issue a=b=q=0x8000000 → `rem_is_zero` after 15 edges.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the divider back-end stages.
// Holds the remainder-sign FSM encoding and the signed remainder width.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_SUB  = 2'd2,
    ST_DONE = 2'd3
  } rem_state_t;

  // Room for a<<(WIDTH-1) minus a full WIDTH x WIDTH product, plus a sign bit.
  function automatic int rem_width(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/rem_mul_step.sv
// One radix-2^RADIX_BITS shift-add step: acc + (digit * b) << (RADIX_BITS * step).
// Purely combinational; the caller owns the accumulator register.
module rem_mul_step #(
  parameter int WIDTH      = 28,
  parameter int RADIX_BITS = 2,
  parameter int STEP_W     = 5
) (
  input  logic [2*WIDTH-1:0]  i_acc,
  input  logic [WIDTH-1:0]    i_b,
  input  logic [RADIX_BITS-1:0] i_digit,
  input  logic [STEP_W-1:0]   i_step,
  output logic [2*WIDTH-1:0]  o_acc
);

  logic [2*WIDTH-1:0] w_pp;
  logic [2*WIDTH-1:0] w_pp_shifted;

  assign w_pp         = {{WIDTH{1'b0}}, i_b} * {{(2*WIDTH-RADIX_BITS){1'b0}}, i_digit};
  assign w_pp_shifted = w_pp << (i_step * RADIX_BITS);
  assign o_acc        = i_acc + w_pp_shifted;

endmodule

// File: rtl/rem_sign.sv
// Remainder-sign stage: R = a*2^(WIDTH-1) - q*b via an iterative multiplier,
// forwarding q with one-hot sign flags to the rounding stage.
module rem_sign
  import div_pkg::*;
#(
  parameter int WIDTH      = 28,
  parameter int ULP        = 4,
  parameter int RADIX_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q_out,
  output logic             rem_is_positive,
  output logic             rem_is_negative,
  output logic             rem_is_zero,
  output rem_state_t       o_dbg_state
);

  localparam int N      = WIDTH / RADIX_BITS;
  localparam int STEP_W = $clog2(N) + 1;
  localparam int RW     = rem_width(WIDTH);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

  // Guard bits must leave at least one integer-weight bit for the rounder.
  if ((WIDTH % RADIX_BITS) != 0 || ULP >= WIDTH) begin : g_param_check
    $error("rem_sign: WIDTH must be a multiple of RADIX_BITS and exceed ULP");
  end

  // Handshake: a transfer happens on any rising edge where valid && ready;
  // valid is held with stable data until then, ready may change freely.
  rem_state_t          r_state;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_q_keep;
  logic [WIDTH-1:0]    r_q_sh;
  logic [STEP_W-1:0]   r_step;
  logic [2*WIDTH-1:0]  r_acc;
  logic [2*WIDTH-1:0]  w_acc_next;
  logic [RW-1:0]       w_rem;

  rem_mul_step #(
    .WIDTH     (WIDTH),
    .RADIX_BITS(RADIX_BITS),
    .STEP_W    (STEP_W)
  ) u_mul_step (
    .i_acc  (r_acc),
    .i_b    (r_b),
    .i_digit(r_q_sh[RADIX_BITS-1:0]),
    .i_step (r_step),
    .o_acc  (w_acc_next)
  );

  assign w_rem = ({{(RW-WIDTH){1'b0}}, r_a} << (WIDTH - 1)) - {1'b0, r_acc};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_a             <= '0;
      r_b             <= '0;
      r_q_keep        <= '0;
      r_q_sh          <= '0;
      r_step          <= '0;
      r_acc           <= '0;
      q_out           <= '0;
      rem_is_positive <= 1'b0;
      rem_is_negative <= 1'b0;
      rem_is_zero     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_q_keep <= q;
            r_q_sh   <= q;
            r_step   <= '0;
            r_acc    <= '0;
            r_state  <= ST_MUL;
          end
        end
        ST_MUL: begin
          r_acc  <= w_acc_next;
          r_q_sh <= r_q_sh >> RADIX_BITS;
          r_step <= r_step + 1'b1;
          if (r_step == LAST_STEP) r_state <= ST_SUB;
        end
        ST_SUB: begin
          // q_out only moves here so it stays put until the next result lands.
          q_out           <= r_q_keep;
          rem_is_zero     <= (w_rem == '0);
          rem_is_negative <= w_rem[RW-1];
          rem_is_positive <= (w_rem != '0) && !w_rem[RW-1];
          r_state         <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rem_sign.sv
// Self-checking bench for rem_sign: scoreboard of expected {q, pos, neg, zero}
// computed from an exact 64-bit remainder model.
module tb_rem_sign;
  import div_pkg::*;

  localparam int W = 28;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] q;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q_out;
  logic         rem_is_positive;
  logic         rem_is_negative;
  logic         rem_is_zero;
  rem_state_t   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W+2:0] exp_q[$];

  rem_sign #(.WIDTH(W), .ULP(4), .RADIX_BITS(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a              (a),
    .b              (b),
    .q              (q),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .q_out          (q_out),
    .rem_is_positive(rem_is_positive),
    .rem_is_negative(rem_is_negative),
    .rem_is_zero    (rem_is_zero),
    .o_dbg_state    (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W+2:0] model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                         input logic [W-1:0] fq);
    longint r;
    r = (longint'(fa) <<< (W - 1)) - longint'(fq) * longint'(fb);
    return {fq, (r > 0), (r < 0), (r == 0)};
  endfunction

  function automatic logic [W+2:0] observed();
    return {q_out, rem_is_positive, rem_is_negative, rem_is_zero};
  endfunction

  // Driver tasks
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W-1:0] tq);
    int n = 0;
    while (!in_ready && n < 100) begin
      step_clk();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready in_ready=%0b required=1", in_ready);
    end
    a        = ta;
    b        = tb;
    q        = tq;
    in_valid = 1'b1;
    step_clk();
    in_valid = 1'b0;
    exp_q.push_back(model(ta, tb, tq));
  endtask

  task automatic recv(input string name, output int lat);
    logic [W+2:0] e;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step_clk();
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout out_valid=%0b required=1", name, out_valid);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected got=%h required=none", name, observed());
    end else begin
      e = exp_q.pop_front();
      if (observed() !== e) begin
        errors++;
        $display("FAIL %s_result got=%h required=%h", name, observed(), e);
      end
    end
    out_ready = 1'b1;
    step_clk();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_release in_ready=%0b out_valid=%0b required=1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || q_out !== '0 || rem_is_positive !== 1'b0 ||
        rem_is_negative !== 1'b0 || rem_is_zero !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL %s ov=%0b ir=%0b q_out=%h flags=%b%b%b state=%0d required ov=0 ir=1 q_out=0 flags=000 state=0",
               name, out_valid, in_ready, q_out, rem_is_positive, rem_is_negative, rem_is_zero, dbg_state);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; q = '0;
    repeat (2) step_clk();
    reset = 1'b0;
    check_reset_state("reset");
  endtask

  task automatic test_exact();
    int lat;
    send(28'h8000000, 28'h8000000, 28'h8000000);
    recv("exact", lat);
    checks++;
    if (lat != 15) begin
      errors++;
      $display("FAIL exact_latency got=%0d required=15", lat);
    end
  endtask

  task automatic test_corner_table();
    logic [W-1:0] ta[5] = '{28'h8000000, 28'h8000000, 28'h0000000, 28'hFFFFFFF, 28'h0000001};
    logic [W-1:0] tb[5] = '{28'h8000000, 28'h8000000, 28'h0000000, 28'hFFFFFFF, 28'h0000000};
    logic [W-1:0] tq[5] = '{28'h7FFFFFF, 28'h8000001, 28'hFFFFFFF, 28'hFFFFFFF, 28'h1234567};
    int lat;
    for (int i = 0; i < 5; i++) begin
      send(ta[i], tb[i], tq[i]);
      recv($sformatf("corner%0d", i), lat);
    end
  endtask

  task automatic test_backpressure();
    logic [W+2:0] e;
    int n = 0;
    send(28'h8000000, 28'h8000000, 28'h8000001);
    while (!out_valid && n < 100) begin
      step_clk();
      n++;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== e) begin
        errors++;
        $display("FAIL bp_hold%0d ov=%0b ir=%0b got=%h required ov=1 ir=0 %h",
                 i, out_valid, in_ready, observed(), e);
      end
      in_valid = 1'b1;
      a = 28'(W'($urandom_range(32'h0FFFFFFF, 0)));
      b = 28'h0000001;
      q = 28'h0000001;
      step_clk();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step_clk();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release ir=%0b ov=%0b required=1/0", in_ready, out_valid);
    end
    repeat (3) step_clk();
    checks++;
    if (dbg_state !== ST_IDLE || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_accept state=%0d ov=%0b required=0/0", dbg_state, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    send(28'hFFFFFFF, 28'h1234567, 28'h0ABCDEF);
    repeat (4) step_clk();
    reset = 1'b1;
    step_clk();
    reset = 1'b0;
    exp_q.delete();
    check_reset_state("reset_mid");
    send(28'h8000000, 28'h8000000, 28'h8000000);
    recv("after_reset", lat);
    checks++;
    if (lat != 15) begin
      errors++;
      $display("FAIL after_reset_latency got=%0d required=15", lat);
    end
  endtask

  task automatic test_throughput();
    logic [W+2:0] e;
    int n = 0;
    out_ready = 1'b1;
    send(28'h4000000, 28'h6000000, 28'h5555555);
    e = exp_q.pop_front();
    while (!in_ready && n < 100) begin
      if (out_valid) begin
        checks++;
        if (observed() !== e) begin
          errors++;
          $display("FAIL tput_result got=%h required=%h", observed(), e);
        end
      end
      step_clk();
      n++;
    end
    out_ready = 1'b0;
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL tput_cycles got=%0d required=16", n);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ra, rb, rq;
    int lat;
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom_range(32'h0FFFFFFF, 0));
      rb = W'($urandom_range(32'h0FFFFFFF, 1));
      rq = (i % 2 == 0) ? W'($urandom_range(32'h0FFFFFFF, 0)) : W'($urandom_range(32'h0000FFFF, 0));
      send(ra, rb, rq);
      recv($sformatf("b2b%0d", i), lat);
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_corner_table();
    test_backpressure();
    test_reset_mid();
    test_throughput();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
